store_cycle_monitor: RTL

- Bus-side performance monitor that sits directly downstream of the single-cycle processor.
- Taps the processor's data-memory write port (MemWrite, ALUResult as address, WriteData) in parallel with the data memory.
- Splits execution into segments, each ending on a qualifying store, and records the per-segment cycle count and stored value.
- Exposes the recorded results through a registered readout port, so per-result cycle accounting is done in hardware rather than in the bench.

---
 rtl/store_cycle_monitor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/store_cycle_monitor.sv
// rtl/store_cycle_monitor.sv - per-segment store cycle monitor with registered readout
//
// Purpose: watches the processor data-memory write port and splits execution
// into segments, each closed by a qualifying store. For every segment the
// cycle count (including the closing store cycle) and the stored value are
// recorded. After N_SEG segments the monitor freezes in DONE until reset.
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   mem_write/addr/wdata     tapped processor MemWrite, ALUResult, WriteData
//   rd_en, rd_idx            readout request and segment index
//   rd_valid/cycles/data     registered readout result, one cycle after rd_en
//   seg_idx                  segment currently being counted
//   total_cycles             cycles spent counting (frozen in DONE)
//   done                     all N_SEG segments recorded
//   overflow                 sticky: a counter tried to step past all-ones
//
// Optional feature macro: STORE_ADDR_FILTER_EN
//   defined   -> only stores with ADDR_LO <= mem_addr <= ADDR_HI close a segment
//   undefined -> every mem_write cycle closes a segment; mem_addr is ignored
module store_cycle_monitor #(
  parameter int          N_SEG   = 20,
  parameter int          CNT_W   = 32,
  parameter int          IDX_W   = 5,
  parameter logic [31:0] ADDR_LO = 32'd80,
  parameter logic [31:0] ADDR_HI = 32'd159
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_write,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_cycles,
  output logic [31:0]      rd_data,
  output logic [IDX_W-1:0] seg_idx,
  output logic [CNT_W-1:0] total_cycles,
  output logic             done,
  output logic             overflow
);

  typedef enum logic {S_COUNT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SEG - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] cyc_mem [N_SEG];
  logic [31:0]      dat_mem [N_SEG];
  logic             qual;
  logic             close_seg;
  logic             cur_sat;
  logic             total_sat;
  logic [CNT_W-1:0] cur_inc;

`ifdef STORE_ADDR_FILTER_EN
  assign qual = mem_write && (mem_addr >= ADDR_LO) && (mem_addr <= ADDR_HI);
`else
  logic unused_addr;
  assign unused_addr = ^{mem_addr, ADDR_LO, ADDR_HI};
  assign qual        = mem_write;
`endif

  // cur_inc serves both as the next idle count and as the length written
  // for a closing segment, since the store cycle belongs to that segment.
  assign cur_sat   = (cur_cnt == CNT_MAX);
  assign total_sat = (total_cycles == CNT_MAX);
  assign cur_inc   = cur_sat ? CNT_MAX : cur_cnt + CNT_W'(1);
  assign done      = (state == S_DONE);

  always_comb begin
    state_next = state;
    close_seg  = 1'b0;
    case (state)
      S_COUNT: begin
        close_seg = qual;
        if (qual && (seg_idx == LAST_IDX)) state_next = S_DONE;
      end
      S_DONE: state_next = S_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_COUNT;
      cur_cnt      <= '0;
      total_cycles <= '0;
      seg_idx      <= '0;
      overflow     <= 1'b0;
      for (int i = 0; i < N_SEG; i++) begin
        cyc_mem[i] <= '0;
        dat_mem[i] <= '0;
      end
    end else begin
      state <= state_next;
      if (state == S_COUNT) begin
        total_cycles <= total_sat ? CNT_MAX : total_cycles + CNT_W'(1);
        if (total_sat || cur_sat) overflow <= 1'b1;
        if (close_seg) begin
          cyc_mem[seg_idx] <= cur_inc;
          dat_mem[seg_idx] <= mem_wdata;
          cur_cnt          <= '0;
          // The last segment leaves seg_idx parked at N_SEG-1.
          if (seg_idx != LAST_IDX) seg_idx <= seg_idx + IDX_W'(1);
        end else begin
          cur_cnt <= cur_inc;
        end
      end
    end
  end

  // Readout samples the arrays before this edge's write lands, so a read
  // and write to the same index return the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      rd_cycles <= '0;
      rd_data   <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_idx <= LAST_IDX) begin
          rd_cycles <= cyc_mem[rd_idx];
          rd_data   <= dat_mem[rd_idx];
        end else begin
          rd_cycles <= '0;
          rd_data   <= '0;
        end
      end
    end
  end

endmodule
